// File: rtl/pfxsum_accel.sv
// pfxsum_accel: streams 512-bit lines over AXI, keeps a running 64-bit-lane prefix sum and reports the round total over SoftReg.
// Define PFXSUM_WRITEBACK_EN to write each line's prefix sums back to WRITE_ADDR.
module pfxsum_accel (
    input  logic         clk,
    input  logic         rst,
    output logic [15:0]  arid_m,
    output logic [63:0]  araddr_m,
    output logic [7:0]   arlen_m,
    output logic [2:0]   arsize_m,
    output logic         arvalid_m,
    input  logic         arready_m,
    input  logic [15:0]  rid_m,
    input  logic [511:0] rdata_m,
    input  logic [1:0]   rresp_m,
    input  logic         rlast_m,
    input  logic         rvalid_m,
    output logic         rready_m,
    output logic [15:0]  awid_m,
    output logic [63:0]  awaddr_m,
    output logic [7:0]   awlen_m,
    output logic [2:0]   awsize_m,
    output logic         awvalid_m,
    input  logic         awready_m,
    output logic [15:0]  wid_m,
    output logic [511:0] wdata_m,
    output logic [63:0]  wstrb_m,
    output logic         wlast_m,
    output logic         wvalid_m,
    input  logic         wready_m,
    input  logic [15:0]  bid_m,
    input  logic [1:0]   bresp_m,
    input  logic         bvalid_m,
    output logic         bready_m,
    input  logic         softreg_req_valid,
    input  logic         softreg_req_isWrite,
    input  logic [31:0]  softreg_req_addr,
    input  logic [63:0]  softreg_req_data,
    output logic         softreg_resp_valid,
    output logic [63:0]  softreg_resp_data
);
    localparam int LANES = 8;
    typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, NEXT} state_t;
    state_t state;
    logic [63:0] read_addr, read_words, read_info, iters, write_addr;
    logic [63:0] total, carry, line, round, acc, rd_val;
    logic [511:0] pfx_line;
    logic done, pending;
    logic rd_req, wr_req, start, round_end, last_round;
    logic [63:0] line_n, round_n;
    logic unused_ok;
    assign arid_m   = 16'd0;
    assign arlen_m  = 8'd0;
    assign arsize_m = 3'd6;
    assign rd_req   = softreg_req_valid && !softreg_req_isWrite;
    assign wr_req   = softreg_req_valid && softreg_req_isWrite;
    assign start    = wr_req && softreg_req_addr == 32'h10;
    assign line_n   = line + 64'd1;
    assign round_n  = round + 64'd1;
    assign round_end  = state == NEXT && (read_words == 64'd0 || line_n == read_words);
    assign last_round = round_n == (iters == 64'd0 ? 64'd1 : iters);
    always_comb begin
        pfx_line = '0;
        acc = carry;
        for (int j = 0; j < LANES; j++) begin
            acc = acc + rdata_m[64*j +: 64];
            pfx_line[64*j +: 64] = acc;
        end
    end
    always_comb begin
        rd_val = softreg_req_addr == 32'h00 ? read_addr :
                 softreg_req_addr == 32'h08 ? read_words :
                 softreg_req_addr == 32'h10 ? read_info :
                 softreg_req_addr == 32'h28 ? iters :
                 softreg_req_addr == 32'h30 ? write_addr : 64'd0;
    end
`ifdef PFXSUM_WRITEBACK_EN
    assign awid_m   = 16'd0;
    assign awlen_m  = 8'd0;
    assign awsize_m = 3'd6;
    assign wid_m    = 16'd0;
    assign wstrb_m  = '1;
    assign wlast_m  = 1'b1;
    assign unused_ok = ^{rid_m, rresp_m, rlast_m, bid_m, bresp_m};
`else
    assign awid_m    = 16'd0;
    assign awaddr_m  = 64'd0;
    assign awlen_m   = 8'd0;
    assign awsize_m  = 3'd0;
    assign awvalid_m = 1'b0;
    assign wid_m     = 16'd0;
    assign wdata_m   = '0;
    assign wstrb_m   = '0;
    assign wlast_m   = 1'b0;
    assign wvalid_m  = 1'b0;
    assign bready_m  = 1'b1;
    assign unused_ok = ^{rid_m, rresp_m, rlast_m, bid_m, bresp_m, bvalid_m, awready_m, wready_m, pfx_line};
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            {read_addr, read_words, read_info, iters, write_addr} <= '0;
            {total, carry, line, round} <= '0;
            done <= 1'b0;
            pending <= 1'b0;
            arvalid_m <= 1'b0;
            araddr_m <= 64'd0;
            rready_m <= 1'b0;
            softreg_resp_valid <= 1'b0;
            softreg_resp_data <= 64'd0;
`ifdef PFXSUM_WRITEBACK_EN
            awvalid_m <= 1'b0;
            awaddr_m <= 64'd0;
            wvalid_m <= 1'b0;
            wdata_m <= '0;
            bready_m <= 1'b0;
`endif
        end else begin
            softreg_resp_valid <= 1'b0;
            if (wr_req) begin
                if (softreg_req_addr == 32'h00) read_addr <= softreg_req_data;
                if (softreg_req_addr == 32'h08) read_words <= softreg_req_data;
                if (softreg_req_addr == 32'h10) read_info <= softreg_req_data;
                if (softreg_req_addr == 32'h28) iters <= softreg_req_data;
                if (softreg_req_addr == 32'h30) write_addr <= softreg_req_data;
            end
            // A held ROUND_DONE read is answered with the carry that becomes the total this cycle.
            if (pending && round_end) begin
                softreg_resp_valid <= 1'b1;
                softreg_resp_data <= carry;
                pending <= 1'b0;
            end else if (rd_req && !pending) begin
                if (softreg_req_addr != 32'h18) begin
                    softreg_resp_valid <= 1'b1;
                    softreg_resp_data <= rd_val;
                end else if (done || round_end) begin
                    softreg_resp_valid <= 1'b1;
                    softreg_resp_data <= done ? total : carry;
                end else begin
                    pending <= 1'b1;
                end
            end
            case (state)
                IDLE: if (start) begin
                    {total, carry, line, round} <= '0;
                    done <= 1'b0;
                    state <= read_words == 64'd0 ? NEXT : AR;
                    arvalid_m <= read_words != 64'd0;
                    araddr_m <= read_addr;
                end
                AR: if (arready_m) begin
                    arvalid_m <= 1'b0;
                    rready_m <= 1'b1;
                    state <= R;
                end
                R: if (rvalid_m) begin
                    rready_m <= 1'b0;
                    carry <= pfx_line[511:448];
`ifdef PFXSUM_WRITEBACK_EN
                    awvalid_m <= 1'b1;
                    awaddr_m <= write_addr + (line << 6);
                    wvalid_m <= 1'b1;
                    wdata_m <= pfx_line;
                    state <= AW_W;
`else
                    state <= NEXT;
`endif
                end
`ifdef PFXSUM_WRITEBACK_EN
                AW_W: begin
                    awvalid_m <= awvalid_m && !awready_m;
                    wvalid_m <= wvalid_m && !wready_m;
                    if ((!awvalid_m || awready_m) && (!wvalid_m || wready_m)) begin
                        bready_m <= 1'b1;
                        state <= B;
                    end
                end
                B: if (bvalid_m) begin
                    bready_m <= 1'b0;
                    state <= NEXT;
                end
`endif
                NEXT: begin
                    line <= round_end ? 64'd0 : line_n;
                    if (round_end) begin
                        total <= carry;
                        done <= 1'b1;
                        carry <= 64'd0;
                        round <= round_n;
                    end
                    if (round_end && last_round) begin
                        state <= IDLE;
                    end else if (round_end && read_words == 64'd0) begin
                        state <= NEXT;
                    end else begin
                        state <= AR;
                        arvalid_m <= 1'b1;
                        araddr_m <= read_addr + ((round_end ? 64'd0 : line_n) << 6);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pfxsum_accel.sv
// tb_pfxsum_accel: directed bench for pfxsum_accel with a small AXI memory emulator (lane j of line k = 8k+j+1).
module tb_pfxsum_accel;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic [15:0] arid_m, rid_m, awid_m, wid_m, bid_m;
    logic [63:0] araddr_m, awaddr_m, wstrb_m, softreg_req_data, softreg_resp_data;
    logic [7:0] arlen_m, awlen_m;
    logic [2:0] arsize_m, awsize_m;
    logic arvalid_m, arready_m, rlast_m, rvalid_m, rready_m, awvalid_m, awready_m;
    logic wlast_m, wvalid_m, wready_m, bvalid_m, bready_m;
    logic [511:0] rdata_m, wdata_m;
    logic [1:0] rresp_m, bresp_m;
    logic softreg_req_valid = 1'b0, softreg_req_isWrite = 1'b0, softreg_resp_valid;
    logic [31:0] softreg_req_addr = 32'd0;
    pfxsum_accel dut (
        .clk(clk), .rst(rst),
        .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
        .arvalid_m(arvalid_m), .arready_m(arready_m),
        .rid_m(rid_m), .rdata_m(rdata_m), .rresp_m(rresp_m), .rlast_m(rlast_m),
        .rvalid_m(rvalid_m), .rready_m(rready_m),
        .awid_m(awid_m), .awaddr_m(awaddr_m), .awlen_m(awlen_m), .awsize_m(awsize_m),
        .awvalid_m(awvalid_m), .awready_m(awready_m),
        .wid_m(wid_m), .wdata_m(wdata_m), .wstrb_m(wstrb_m), .wlast_m(wlast_m),
        .wvalid_m(wvalid_m), .wready_m(wready_m),
        .bid_m(bid_m), .bresp_m(bresp_m), .bvalid_m(bvalid_m), .bready_m(bready_m),
        .softreg_req_valid(softreg_req_valid), .softreg_req_isWrite(softreg_req_isWrite),
        .softreg_req_addr(softreg_req_addr), .softreg_req_data(softreg_req_data),
        .softreg_resp_valid(softreg_resp_valid), .softreg_resp_data(softreg_resp_data)
    );
    int n_cmp = 0, n_bad = 0;
    logic stall = 1'b0, ones_mode = 1'b0;
    logic [63:0] addr_log[$];
    logic [63:0] aw_log[$];
    logic [511:0] w_log[$];
    logic [63:0] s_log[$];
    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [511:0] mk_line(input logic [63:0] a);
        logic [511:0] v;
        for (int j = 0; j < 8; j++) v[64*j +: 64] = ones_mode ? 64'hFFFF_FFFF_FFFF_FFFF : 8 * (a >> 6) + j + 1;
        return v;
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic sr_write(input logic [31:0] a, input logic [63:0] d);
        softreg_req_valid = 1'b1;
        softreg_req_isWrite = 1'b1;
        softreg_req_addr = a;
        softreg_req_data = d;
        tick();
        softreg_req_valid = 1'b0;
        softreg_req_isWrite = 1'b0;
    endtask
    task automatic sr_read(input logic [31:0] a, input int limit, output logic [63:0] d, output int lat, output logic ok);
        softreg_req_valid = 1'b1;
        softreg_req_isWrite = 1'b0;
        softreg_req_addr = a;
        tick();
        softreg_req_valid = 1'b0;
        lat = 1;
        while (!softreg_resp_valid && lat < limit) begin
            tick();
            lat++;
        end
        ok = softreg_resp_valid;
        d = softreg_resp_data;
    endtask
    task automatic setup(input logic [63:0] words, input logic [63:0] it);
        sr_write(32'h00, 64'd0);
        sr_write(32'h08, words);
        sr_write(32'h28, it);
        sr_write(32'h30, 64'h200);
        addr_log.delete();
        aw_log.delete();
        w_log.delete();
        s_log.delete();
    endtask
    task automatic wait_lines(input string tag, input int n, input int limit);
        int c = 0;
        while (addr_log.size() < n && c < limit) begin
            tick();
            c++;
        end
        repeat (12) tick();
        check(tag, addr_log.size(), n);
    endtask
    // Read side: arready one cycle after arvalid, then a single data beat unless stalled.
    initial begin
        int phase = 0;
        logic [63:0] a_q = 0;
        arready_m = 1'b0; rvalid_m = 1'b0; rdata_m = '0;
        rid_m = 16'd0; rresp_m = 2'd0; rlast_m = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                arready_m = 1'b0; rvalid_m = 1'b0; phase = 0;
            end else if (phase == 0) begin
                if (arvalid_m) begin arready_m = 1'b1; a_q = araddr_m; phase = 1; end
            end else if (phase == 1) begin
                arready_m = 1'b0;
                addr_log.push_back(a_q);
                phase = 4;
            end else if (phase == 3) begin
                rvalid_m = 1'b0;
                phase = 0;
            end
            if (!rst && (phase == 4 || phase == 2)) begin
                if (phase == 4 && !stall) begin
                    rvalid_m = 1'b1; rdata_m = mk_line(a_q); phase = 2;
                end
                if (phase == 2 && rready_m) phase = 3;
            end
        end
    end
`ifdef PFXSUM_WRITEBACK_EN
    initial begin
        logic got_aw = 1'b0, got_w = 1'b0, b_hs = 1'b0;
        awready_m = 1'b0; wready_m = 1'b0; bvalid_m = 1'b0; bid_m = 16'd0; bresp_m = 2'd0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                bvalid_m = 1'b0; got_aw = 1'b0; got_w = 1'b0; b_hs = 1'b0;
            end else begin
                awready_m = 1'b1;
                wready_m = 1'b1;
                if (b_hs) begin bvalid_m = 1'b0; b_hs = 1'b0; end
                else if (bvalid_m) b_hs = bready_m;
                else if (got_aw && got_w) begin bvalid_m = 1'b1; got_aw = 1'b0; got_w = 1'b0; end
                if (awvalid_m) begin aw_log.push_back(awaddr_m); got_aw = 1'b1; end
                if (wvalid_m) begin w_log.push_back(wdata_m); s_log.push_back(wstrb_m); got_w = 1'b1; end
            end
        end
    end
`else
    initial begin
        awready_m = 1'b0; wready_m = 1'b0; bvalid_m = 1'b0; bid_m = 16'd0; bresp_m = 2'd0;
    end
`endif
    initial begin
        logic [63:0] d;
        int lat, errs;
        logic ok;
        softreg_req_data = 64'd0;
        repeat (3) tick();
        check("rst_arvalid", arvalid_m, 0);
        check("rst_rready", rready_m, 0);
        check("rst_awvalid", awvalid_m, 0);
        check("rst_wvalid", wvalid_m, 0);
        check("rst_resp_valid", softreg_resp_valid, 0);
        check("rst_resp_data", softreg_resp_data, 0);
        rst = 1'b0;
        tick();
        sr_write(32'h00, 64'h1111);
        sr_write(32'h30, 64'hABCD);
        sr_write(32'h40, 64'h5555);
        sr_read(32'h00, 10, d, lat, ok);
        check("rd_read_addr", d, 64'h1111);
        check("rd_lat", lat, 1);
        tick();
        check("rd_pulse", softreg_resp_valid, 0);
        sr_read(32'h30, 10, d, lat, ok);
        check("rd_write_addr", d, 64'hABCD);
        sr_read(32'h40, 10, d, lat, ok);
        check("rd_unmapped", d, 0);
        check("rd_unmapped_ok", ok, 1);
        // 256 rounds of 4 lines, second start mid-run, ROUND_DONE read at ~cycle 1000.
        setup(64'd4, 64'd256);
        sr_write(32'h10, 64'd0);
        check("start_arvalid", arvalid_m, 1);
        check("start_araddr", araddr_m, 0);
        repeat (400) tick();
        sr_write(32'h10, 64'd7);
        repeat (600) tick();
        sr_read(32'h18, 10, d, lat, ok);
        check("total_528", d, 64'd528);
        check("total_lat", lat, 1);
        wait_lines("lines_1024", 1024, 8000);
        errs = 0;
        foreach (addr_log[i]) if (addr_log[i] != 64'(i % 4) * 64) errs++;
        check("addr_seq", errs, 0);
        sr_read(32'h08, 10, d, lat, ok);
        check("rd_read_words", d, 64'd4);
        // ROUND_DONE read right after start is held until the first round ends.
        setup(64'd4, 64'd2);
        sr_write(32'h10, 64'd0);
        sr_read(32'h18, 200, d, lat, ok);
        check("held_ok", ok, 1);
        check("held_total", d, 64'd528);
        check("held_lat", lat > 5, 1);
        wait_lines("lines_8", 8, 400);
`ifdef PFXSUM_WRITEBACK_EN
        begin
            int exp_l[8] = '{1, 3, 6, 10, 15, 21, 28, 36};
            logic [511:0] ew;
            for (int j = 0; j < 8; j++) ew[64*j +: 64] = exp_l[j];
            setup(64'd1, 64'd1);
            sr_write(32'h10, 64'd0);
            wait_lines("wb_lines", 1, 100);
            check("wb_count", aw_log.size(), 1);
            check("wb_wcount", w_log.size(), 1);
            if (aw_log.size() > 0) check("wb_awaddr", aw_log[0], 64'h200);
            if (w_log.size() > 0) check("wb_wdata", w_log[0], ew);
            if (s_log.size() > 0) check("wb_wstrb", s_log[0], 64'hFFFF_FFFF_FFFF_FFFF);
        end
`endif
        // All-ones lanes wrap to -8.
        ones_mode = 1'b1;
        setup(64'd1, 64'd1);
        sr_write(32'h10, 64'd0);
        wait_lines("lines_ones", 1, 100);
        sr_read(32'h18, 10, d, lat, ok);
        check("total_wrap", d, 64'hFFFF_FFFF_FFFF_FFF8);
        ones_mode = 1'b0;
        // Zero-line rounds complete at once and never touch memory.
        setup(64'd0, 64'd3);
        sr_write(32'h10, 64'd0);
        sr_read(32'h18, 50, d, lat, ok);
        check("zero_ok", ok, 1);
        check("zero_total", d, 0);
        repeat (20) tick();
        check("zero_no_reads", addr_log.size(), 0);
        // Reset while stalled in the data phase.
        setup(64'd4, 64'd1);
        stall = 1'b1;
        sr_write(32'h10, 64'd0);
        repeat (6) tick();
        check("stall_rready", rready_m, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stall = 1'b0;
        check("mid_rst_arvalid", arvalid_m, 0);
        check("mid_rst_rready", rready_m, 0);
        check("mid_rst_awvalid", awvalid_m, 0);
        check("mid_rst_wvalid", wvalid_m, 0);
        sr_read(32'h18, 20, d, lat, ok);
        check("rst_held", ok, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sr_read(32'h08, 10, d, lat, ok);
        check("rst_words_cleared", d, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
